// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// mode encodings, the segment-width helper and the parameter legality check.
package cla_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of the slice of the operands resolved by each pipeline stage.
  function automatic int segWidth(input int dataW, input int stages);
    return dataW / stages;
  endfunction

  // True when the operand width splits evenly into stages, every stage has at
  // least four bits, and each segment splits evenly into lookahead groups.
  function automatic bit paramsOk(input int dataW, input int stages, input int groupW);
    if (stages < 1 || groupW < 1) return 1'b0;
    if (dataW % stages != 0) return 1'b0;
    if (stages > dataW / 4) return 1'b0;
    return ((dataW / stages) % groupW) == 0;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit carry-lookahead adder slice. Carries are resolved in
// full lookahead inside each GROUP_W-bit group; group carries chain from one
// group to the next. C_msb is the carry into the top bit, used for overflow.
module cla_segment #(
  parameter int SEG_W   = 8,
  parameter int GROUP_W = 4
) (
  input  logic [SEG_W-1:0] A,
  input  logic [SEG_W-1:0] B,
  input  logic             Cin,
  output logic [SEG_W-1:0] Sum,
  output logic             Cout,
  output logic             C_msb
);

  localparam int NUM_GROUPS = SEG_W / GROUP_W;

  logic [SEG_W-1:0] gen;
  logic [SEG_W-1:0] prop;
  logic [SEG_W:0]   carry;

  // Lookahead carry network: carry i of a group is the OR of every generate
  // below it propagated up, plus the group carry-in propagated through all.
  always_comb begin
    int   base;
    logic acc;
    logic term;
    gen      = A & B;
    prop     = A ^ B;
    carry    = '0;
    carry[0] = Cin;
    base     = 0;
    acc      = 1'b0;
    term     = 1'b0;
    for (int grp = 0; grp < NUM_GROUPS; grp++) begin
      base = grp * GROUP_W;
      for (int i = 1; i <= GROUP_W; i++) begin
        acc = carry[base];
        for (int j = 0; j < i; j++) acc = acc & prop[base + j];
        for (int j = 0; j < i; j++) begin
          term = gen[base + j];
          for (int m = j + 1; m < i; m++) term = term & prop[base + m];
          acc = acc | term;
        end
        carry[base + i] = acc;
      end
    end
  end

  assign Sum   = prop ^ carry[SEG_W-1:0];
  assign Cout  = carry[SEG_W];
  assign C_msb = carry[SEG_W-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one segment
// of the operands and registers the carry for the next stage. A valid/ready
// handshake at both ends lets empty stages fill even while the output stalls.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int STAGES  = 4,
  parameter int GROUP_W = 4
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iA,
  input  logic [DATA_W-1:0] iB,
  input  logic              iCarryIn,
  input  logic              iSub,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oSum,
  output logic              oCarry,
  output logic              oOverflow,
  output logic              oZero
);

  localparam int SEG_W = segWidth(DATA_W, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!paramsOk(DATA_W, STAGES, GROUP_W)) begin : gParamCheck
    $error("cla_addsub_pipe: DATA_W/STAGES/GROUP_W combination is illegal");
  end

  logic [STAGES-1:0] validQ;
  logic [STAGES-1:0] carryQ;
  logic [STAGES-1:0] cMsbQ;
  logic [STAGES-1:0] subQ;
  logic [DATA_W-1:0] aQ   [STAGES];
  logic [DATA_W-1:0] bQ   [STAGES];
  logic [DATA_W-1:0] sumQ [STAGES];

  logic [STAGES-1:0] load;
  logic [SEG_W-1:0]  segSum [STAGES];
  logic [STAGES-1:0] segCout;
  logic [STAGES-1:0] segCmsb;
  logic [DATA_W-1:0] bFirst;

  assign bFirst = (iSub == MODE_SUB) ? ~iB : iB;

  // A stage may load when it or any stage after it is empty, or when the
  // consumer is taking the result; this collapses bubbles without a path
  // from iValid.
  always_comb begin
    logic chain;
    chain = iReady;
    load  = '0;
    for (int k = LAST; k >= 0; k--) begin
      chain   = chain | ~validQ[k];
      load[k] = chain;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gSeg
    logic [SEG_W-1:0] segA;
    logic [SEG_W-1:0] segB;
    logic             segCin;
    if (k == 0) begin : gFirst
      assign segA   = iA[0 +: SEG_W];
      assign segB   = bFirst[0 +: SEG_W];
      assign segCin = iCarryIn;
    end else begin : gNext
      assign segA   = aQ[k-1][k*SEG_W +: SEG_W];
      assign segB   = (subQ[k-1] == MODE_SUB) ? ~bQ[k-1][k*SEG_W +: SEG_W]
                                              :  bQ[k-1][k*SEG_W +: SEG_W];
      assign segCin = carryQ[k-1];
    end
    cla_segment #(
      .SEG_W  (SEG_W),
      .GROUP_W(GROUP_W)
    ) uSeg (
      .A    (segA),
      .B    (segB),
      .Cin  (segCin),
      .Sum  (segSum[k]),
      .Cout (segCout[k]),
      .C_msb(segCmsb[k])
    );
  end

  // Stage registers: stage 0 captures the operands together with the first
  // segment; later stages shift the operation along and add their segment.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      validQ <= '0;
      carryQ <= '0;
      cMsbQ  <= '0;
      subQ   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        aQ[k]   <= '0;
        bQ[k]   <= '0;
        sumQ[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        validQ[0] <= iValid;
        aQ[0]     <= iA;
        bQ[0]     <= iB;
        subQ[0]   <= iSub;
        sumQ[0]   <= DATA_W'(segSum[0]);
        carryQ[0] <= segCout[0];
        cMsbQ[0]  <= segCmsb[0];
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          validQ[k]                    <= validQ[k-1];
          aQ[k]                        <= aQ[k-1];
          bQ[k]                        <= bQ[k-1];
          subQ[k]                      <= subQ[k-1];
          sumQ[k]                      <= sumQ[k-1];
          sumQ[k][k*SEG_W +: SEG_W]    <= segSum[k];
          carryQ[k]                    <= segCout[k];
          cMsbQ[k]                     <= segCmsb[k];
        end
      end
    end
  end

  assign oReady    = load[0];
  assign oValid    = validQ[LAST];
  assign oSum      = sumQ[LAST];
  assign oCarry    = carryQ[LAST];
  assign oOverflow = carryQ[LAST] ^ cMsbQ[LAST];
  assign oZero     = validQ[LAST] && (sumQ[LAST] == '0);

endmodule
